// File: rtl/ft_alu_result_checker.sv
// Result checker for the duplicated 3-bit ALU.
// Classifies each X/Y result pair, asks upstream to re-issue on compute errors and delivers one tagged result per op.
module ft_alu_result_checker #(
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       x_sum,
    input  logic             x_carry,
    input  logic [1:0]       x_err,
    input  logic [2:0]       y_sum,
    input  logic             y_carry,
    input  logic [1:0]       y_err,
    output logic             retry_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sum,
    output logic             out_carry,
    output logic [1:0]       out_status,
    output logic [1:0]       out_retries,
    output logic [CNT_W-1:0] err_count,
    output logic             fatal,
    input  logic             fatal_clr
);

    typedef enum logic [1:0] {S_IDLE, S_RETRY, S_OUT, S_HALT} state_t;
    // Encoding doubles as the out_status value for that class.
    typedef enum logic [1:0] {C_CLEAN, C_INPUT, C_COMPUTE, C_FAULT} cls_t;

    localparam logic [1:0]       MAX_R   = 2'(MAX_RETRY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    cls_t             cls;
    logic             accept;
    logic [1:0]       attempt_q;
    logic             retry_req_q;
    logic [2:0]       out_sum_q;
    logic             out_carry_q;
    logic [1:0]       out_status_q;
    logic [1:0]       out_retries_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;
    logic             fatal_q;

    always_comb begin
        cls = C_CLEAN;
        if (x_err == 2'b00 || y_err == 2'b00 || x_err != y_err)
            cls = C_FAULT;
        else if (x_err == 2'b11 || y_err == 2'b11)
            cls = C_INPUT;
        else if (x_err == 2'b01 || y_err == 2'b01 || {x_carry, x_sum} != {y_carry, y_sum})
            cls = C_COMPUTE;
    end

    assign accept = in_valid && (state_q == S_IDLE);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && cls != C_CLEAN && err_cnt_q != CNT_MAX)
            err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            attempt_q     <= 2'd0;
            retry_req_q   <= 1'b0;
            out_sum_q     <= 3'd0;
            out_carry_q   <= 1'b0;
            out_status_q  <= 2'd0;
            out_retries_q <= 2'd0;
            err_cnt_q     <= '0;
            fatal_q       <= 1'b0;
        end else begin
            retry_req_q <= 1'b0;
            err_cnt_q   <= err_cnt_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (cls == C_COMPUTE && attempt_q < MAX_R) begin
                            attempt_q   <= attempt_q + 2'd1;
                            retry_req_q <= 1'b1;
                            state_q     <= S_RETRY;
                        end else begin
                            out_sum_q     <= x_sum;
                            out_carry_q   <= x_carry;
                            out_status_q  <= 2'(cls);
                            out_retries_q <= attempt_q;
                            if (cls == C_FAULT)
                                fatal_q <= 1'b1;
                            state_q <= S_OUT;
                        end
                    end
                end
                S_RETRY: state_q <= S_IDLE;
                S_OUT: begin
                    if (out_ready) begin
                        attempt_q <= 2'd0;
                        state_q   <= fatal_q ? S_HALT : S_IDLE;
                    end
                end
                S_HALT: begin
                    if (fatal_clr) begin
                        fatal_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign retry_req   = retry_req_q;
    assign out_sum     = out_sum_q;
    assign out_carry   = out_carry_q;
    assign out_status  = out_status_q;
    assign out_retries = out_retries_q;
    assign err_count   = err_cnt_q;
    assign fatal       = fatal_q;

endmodule

// File: tb/tb_ft_alu_result_checker.sv
// Bench for ft_alu_result_checker: vector table plus retry/hold/fault/reset sequences, scoreboard on outputs.
module tb_ft_alu_result_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready, fatal_clr;
    logic [2:0] x_sum, y_sum;
    logic       x_carry, y_carry;
    logic [1:0] x_err, y_err;

    logic       in_ready, retry_req, out_valid, out_carry, fatal;
    logic [2:0] out_sum;
    logic [1:0] out_status, out_retries;
    logic [7:0] err_count;

    logic       s_in_ready, s_retry_req, s_out_valid, s_out_carry, s_fatal;
    logic [2:0] s_out_sum;
    logic [1:0] s_out_status, s_out_retries;
    logic [1:0] s_err_count;

    ft_alu_result_checker #(.MAX_RETRY(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_sum(x_sum), .x_carry(x_carry), .x_err(x_err),
        .y_sum(y_sum), .y_carry(y_carry), .y_err(y_err),
        .retry_req(retry_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_status(out_status),
        .out_retries(out_retries), .err_count(err_count), .fatal(fatal),
        .fatal_clr(fatal_clr)
    );

    // Narrow-counter copy sharing all inputs; only its saturation point differs.
    ft_alu_result_checker #(.MAX_RETRY(2), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .x_sum(x_sum), .x_carry(x_carry), .x_err(x_err),
        .y_sum(y_sum), .y_carry(y_carry), .y_err(y_err),
        .retry_req(s_retry_req), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sum(s_out_sum), .out_carry(s_out_carry), .out_status(s_out_status),
        .out_retries(s_out_retries), .err_count(s_err_count), .fatal(s_fatal),
        .fatal_clr(fatal_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] xs; logic xc; logic [1:0] xe;
        logic [2:0] ys; logic yc; logic [1:0] ye;
        logic       rtr; logic [1:0] st; logic [1:0] nr;
    } vec_t;

    typedef struct {
        logic rtr; logic [2:0] sum; logic c; logic [1:0] st; logic [1:0] nr;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[11];
    int   checks = 0;
    int   errors = 0;
    int   exp_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] xs, input logic xc, input logic [1:0] xe,
                                input logic [2:0] ys, input logic yc, input logic [1:0] ye,
                                input logic rtr, input logic [1:0] st, input logic [1:0] nr);
        vec_t v;
        v.xs = xs; v.xc = xc; v.xe = xe; v.ys = ys; v.yc = yc; v.ye = ye;
        v.rtr = rtr; v.st = st; v.nr = nr;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && (retry_req || (out_valid && out_ready))) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected retry_req=%0b out_valid=%0b required=no_output", retry_req, out_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("retry_req", retry_req, e.rtr);
                chk("out_valid", out_valid, !e.rtr);
                if (!e.rtr) begin
                    chk("out_sum", out_sum, e.sum);
                    chk("out_carry", out_carry, e.c);
                    chk("out_status", out_status, e.st);
                    chk("out_retries", out_retries, e.nr);
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
        if (!in_ready) return;
        x_sum = v.xs; x_carry = v.xc; x_err = v.xe;
        y_sum = v.ys; y_carry = v.yc; y_err = v.ye;
        in_valid = 1'b1;
        e.rtr = v.rtr; e.sum = v.xs; e.c = v.xc; e.st = v.st; e.nr = v.nr;
        sb.push_back(e);
        if (v.rtr || v.st != 2'b00) exp_err++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_sum = 3'($urandom); y_sum = 3'($urandom); x_err = 2'($urandom); y_err = 2'($urandom);
        @(negedge clk);
        if (v.rtr) chk("retry_latency", retry_req, 1);
        else       chk("out_latency", out_valid, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_counts();
        chk("err_count", err_count, (exp_err > 255) ? 255 : exp_err);
        chk("err_count_small", s_err_count, (exp_err > 3) ? 3 : exp_err);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        fatal_clr = 1'b1;
        @(posedge clk);
        #1;
        fatal_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fatal_clr = 1'b0;
        x_sum = '0; x_carry = 1'b0; x_err = '0; y_sum = '0; y_carry = 1'b0; y_err = '0;

        tbl[0]  = mk(3'b101, 1'b0, 2'b10, 3'b101, 1'b0, 2'b10, 1'b0, 2'b00, 2'd0);
        tbl[1]  = mk(3'b011, 1'b0, 2'b01, 3'b011, 1'b0, 2'b01, 1'b1, 2'b00, 2'd0);
        tbl[2]  = mk(3'b011, 1'b0, 2'b10, 3'b011, 1'b0, 2'b10, 1'b0, 2'b00, 2'd1);
        tbl[3]  = mk(3'b010, 1'b0, 2'b10, 3'b011, 1'b0, 2'b10, 1'b1, 2'b00, 2'd0);
        tbl[4]  = mk(3'b010, 1'b0, 2'b10, 3'b011, 1'b0, 2'b10, 1'b1, 2'b00, 2'd0);
        tbl[5]  = mk(3'b010, 1'b0, 2'b10, 3'b011, 1'b0, 2'b10, 1'b0, 2'b10, 2'd2);
        tbl[6]  = mk(3'b110, 1'b1, 2'b11, 3'b110, 1'b1, 2'b11, 1'b0, 2'b01, 2'd0);
        tbl[7]  = mk(3'b001, 1'b0, 2'b11, 3'b100, 1'b1, 2'b11, 1'b0, 2'b01, 2'd0);
        tbl[8]  = mk(3'b111, 1'b1, 2'b10, 3'b111, 1'b0, 2'b10, 1'b1, 2'b00, 2'd0);
        tbl[9]  = mk(3'b000, 1'b0, 2'b11, 3'b000, 1'b0, 2'b11, 1'b0, 2'b01, 2'd1);
        tbl[10] = mk(3'b111, 1'b1, 2'b10, 3'b111, 1'b1, 2'b10, 1'b0, 2'b00, 2'd0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_retry_req", retry_req, 0);
        chk("rst_fatal", fatal, 0);
        chk("rst_out_status", out_status, 0);
        chk_counts();

        foreach (tbl[i]) begin
            drive(tbl[i]);
            drain();
            chk_counts();
        end

        // Consumer stall: result must hold while out_ready is low.
        out_ready = 1'b0;
        drive(mk(3'b010, 1'b0, 2'b11, 3'b010, 1'b0, 2'b11, 1'b0, 2'b01, 2'd0));
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, 3'b010);
            chk("hold_status", out_status, 2'b01);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();
        chk_counts();

        // Invalid code on X: fault, then HALT ignoring new input until cleared.
        drive(mk(3'b100, 1'b0, 2'b00, 3'b100, 1'b0, 2'b10, 1'b0, 2'b11, 2'd0));
        drain();
        @(negedge clk);
        chk("halt_fatal", fatal, 1);
        chk("halt_in_ready", in_ready, 0);
        x_sum = 3'b001; y_sum = 3'b001; x_err = 2'b01; y_err = 2'b01; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("halt_ignore_valid", out_valid, 0);
        chk("halt_ignore_retry", retry_req, 0);
        in_valid = 1'b0;
        chk_counts();
        pulse_clr();
        chk("clr_fatal", fatal, 0);
        chk("clr_in_ready", in_ready, 1);

        // Mismatched codes: fault; fatal_clr while in OUT must be ignored.
        out_ready = 1'b0;
        drive(mk(3'b101, 1'b0, 2'b11, 3'b101, 1'b0, 2'b01, 1'b0, 2'b11, 2'd0));
        pulse_clr();
        chk("clr_ignored_fatal", fatal, 1);
        chk("clr_ignored_valid", out_valid, 1);
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("halt2_in_ready", in_ready, 0);
        chk("halt2_fatal", fatal, 1);
        pulse_clr();
        chk("clr2_fatal", fatal, 0);
        chk_counts();

        // Asynchronous reset while in RETRY; attempt count must clear too.
        @(negedge clk);
        x_sum = 3'b010; x_carry = 1'b0; x_err = 2'b10;
        y_sum = 3'b011; y_carry = 1'b0; y_err = 2'b10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_rst_retry", retry_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_retry_req", retry_req, 0);
        chk("async_in_ready", in_ready, 1);
        chk("async_err_count", err_count, 0);
        chk("async_err_small", s_err_count, 0);
        exp_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(tbl[0]);
        drain();
        chk_counts();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
